vga_tape_view: RTL

VGA_TAPE_VIEW -- requirements
Module: vga_tape_view

---
 rtl/vga_tape_view.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/vga_tape_view.sv
// Maps a 2D pixel raster onto a linear byte-per-cell tape and colours each cell.
// Optional cursor highlight is enabled by defining VGA_TAPE_CURSOR_EN.
module vga_tape_view #(
  parameter int   ADDR_W     = 15,
  parameter int   CELL_SHIFT = 3,
  parameter int   H_ACTIVE   = 640,
  parameter int   MEM_LAT    = 1,
  parameter logic SYNC_IDLE  = 1'b1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [9:0]        counter_x,
  input  logic [9:0]        counter_y,
  input  logic              in_display_area,
  input  logic              h_sync_in,
  input  logic              v_sync_in,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] cursor_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_cell,
  output logic [3:0]        r,
  output logic [3:0]        g,
  output logic [3:0]        b,
  output logic              vga_h_sync,
  output logic              vga_v_sync
);

  localparam int DL = 1 + MEM_LAT;
  localparam logic [ADDR_W-1:0] COLS = ADDR_W'(H_ACTIVE >> CELL_SHIFT);

  logic              w_frame_start;
  logic              w_new_row;
  logic              w_new_col;
  logic              w_de0;
  logic [ADDR_W-1:0] w_row_next;
  logic [ADDR_W-1:0] w_addr_next;
  logic              w_cur;
  logic [3:0]        w_red;
  logic [3:0]        w_grn;
  logic [3:0]        w_blu;
  logic [1:0]        w_mode;

  logic [ADDR_W-1:0] r_row_acc;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_armed;
  logic [DL-1:0]     r_de_sr;
  logic [DL-1:0]     r_hs_sr;
  logic [DL-1:0]     r_vs_sr;
  logic [1:0]        r_mode_sr [DL];
  logic [3:0]        r_red;
  logic [3:0]        r_grn;
  logic [3:0]        r_blu;
  logic              r_hsync;
  logic              r_vsync;

  assign w_frame_start = (counter_x == 10'd0) && (counter_y == 10'd0);
  assign w_new_row     = (counter_y[CELL_SHIFT-1:0] == '0);
  assign w_new_col     = (counter_x[CELL_SHIFT-1:0] == '0);
  // Nothing is displayed until a frame start has latched a valid base.
  assign w_de0         = in_display_area & (r_armed | w_frame_start);

  // Row accumulator holds base + row*COLS; the address register doubles as
  // the column accumulator, so no multiplier is needed.
  always_comb begin
    w_row_next  = r_row_acc;
    w_addr_next = r_mem_addr;
    if (w_frame_start) begin
      w_row_next  = base_addr;
      w_addr_next = base_addr;
    end else if (counter_x == 10'd0) begin
      if (w_new_row) begin
        w_row_next = r_row_acc + COLS;
      end
      w_addr_next = w_row_next;
    end else if (w_new_col) begin
      w_addr_next = r_mem_addr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_row_acc  <= '0;
      r_mem_addr <= '0;
      r_armed    <= 1'b0;
    end else begin
      r_row_acc  <= w_row_next;
      r_mem_addr <= w_addr_next;
      if (w_frame_start) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign mem_addr = r_mem_addr;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_de_sr <= '0;
      r_hs_sr <= {DL{SYNC_IDLE}};
      r_vs_sr <= {DL{SYNC_IDLE}};
    end else begin
      r_de_sr <= {r_de_sr[DL-2:0], w_de0};
      r_hs_sr <= {r_hs_sr[DL-2:0], h_sync_in};
      r_vs_sr <= {r_vs_sr[DL-2:0], v_sync_in};
    end
  end

  generate
    for (genvar gi = 0; gi < DL; gi++) begin : g_mode_pipe
      if (gi == 0) begin : g_first
        always_ff @(posedge clk) begin
          if (!resetn) r_mode_sr[gi] <= 2'd0;
          else         r_mode_sr[gi] <= mode;
        end
      end else begin : g_rest
        always_ff @(posedge clk) begin
          if (!resetn) r_mode_sr[gi] <= 2'd0;
          else         r_mode_sr[gi] <= r_mode_sr[gi-1];
        end
      end
    end
  endgenerate

`ifdef VGA_TAPE_CURSOR_EN
  logic [DL-1:0] r_cur_sr;

  always_ff @(posedge clk) begin
    if (!resetn) r_cur_sr <= '0;
    else         r_cur_sr <= {r_cur_sr[DL-2:0], (w_addr_next == cursor_addr)};
  end

  assign w_cur = r_cur_sr[DL-1];
`else
  logic w_unused_cursor;

  assign w_unused_cursor = ^cursor_addr;
  assign w_cur           = 1'b0;
`endif

  assign w_mode = r_mode_sr[DL-1];

  always_comb begin
    w_red = {mem_cell[2:0], mem_cell[0]};
    w_grn = {mem_cell[5:3], mem_cell[3]};
    w_blu = {mem_cell[7:6], mem_cell[7:6]};
    case (w_mode)
      2'd1: begin
        w_red = mem_cell[7:4];
        w_grn = mem_cell[7:4];
        w_blu = mem_cell[7:4];
      end
      2'd2: begin
        w_red = 4'h0;
        w_grn = (mem_cell != 8'h00) ? 4'hF : 4'h0;
        w_blu = mem_cell[7:4];
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_red   <= 4'h0;
      r_grn   <= 4'h0;
      r_blu   <= 4'h0;
      r_hsync <= SYNC_IDLE;
      r_vsync <= SYNC_IDLE;
    end else begin
      r_red   <= r_de_sr[DL-1] ? (w_red ^ {4{w_cur}}) : 4'h0;
      r_grn   <= r_de_sr[DL-1] ? (w_grn ^ {4{w_cur}}) : 4'h0;
      r_blu   <= r_de_sr[DL-1] ? (w_blu ^ {4{w_cur}}) : 4'h0;
      r_hsync <= r_hs_sr[DL-1];
      r_vsync <= r_vs_sr[DL-1];
    end
  end

  assign r          = r_red;
  assign g          = r_grn;
  assign b          = r_blu;
  assign vga_h_sync = r_hsync;
  assign vga_v_sync = r_vsync;

endmodule
